// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for the fetch stage: the PC link, the program-memory req/ack port
// and the decoder-side instruction queue head.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 13,
  parameter int INSTR_W = 14
);
  logic [ADDR_W-1:0]  pc_in;
  logic               incr_pc_en;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               flush;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;

  // The fetch unit itself.
  modport master (
    input  pc_in, imem_ack, imem_rdata, flush, instr_ready,
    output incr_pc_en, imem_req, imem_addr, instr_valid, instr_out, instr_pc
  );

  // The surrounding PC, program memory and decoder.
  modport slave (
    output pc_in, imem_ack, imem_rdata, flush, instr_ready,
    input  incr_pc_en, imem_req, imem_addr, instr_valid, instr_out, instr_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: requests words at the current PC, pulses the PC
// increment per accepted word, and buffers words in a small prefetch queue.
module instr_fetch_unit #(
  parameter int ADDR_W  = 13,
  parameter int INSTR_W = 14,
  parameter int DEPTH   = 2
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W-1:0]  req_addr;
  logic [INSTR_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0]  q_pc   [DEPTH];

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               push;
  logic               pop;
  logic               head_valid;

  // NOTE: every signal driven here gets a default first, so no path can hold a
  // stale value and infer a latch.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    addr      = '0;
    push      = 1'b0;
    unique case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        req  = (count < FULL);
        addr = bus.pc_in;
        push = req && bus.imem_ack && !bus.flush;
        // A flushed request that memory has not answered must still be
        // completed at its original address before fetching resumes.
        if (bus.flush && req && !bus.imem_ack) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        req  = 1'b1;
        addr = req_addr;
        if (bus.imem_ack) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign head_valid      = (count != '0) && !bus.flush;
  assign pop             = head_valid && bus.instr_ready;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = addr;
  assign bus.incr_pc_en  = push;
  assign bus.instr_valid = head_valid;
  assign bus.instr_out   = q_data[rd_ptr];
  assign bus.instr_pc    = q_pc[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: the queue storage is reset as well, because the head drives
  // instr_out/instr_pc directly and those must read 0 while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      req_addr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      if (state == S_FETCH && req) req_addr <= bus.pc_in;

      if (bus.flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          q_data[wr_ptr] <= bus.imem_rdata;
          q_pc[wr_ptr]   <= bus.pc_in;
          wr_ptr         <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the program counter.
- Reads the 13-bit PC, fetches 14-bit instruction words from program memory over a req/ack handshake, and pulses the PC increment enable once per accepted word.
- Buffers fetched words in a small prefetch queue for the decoder.
- On flush (PCL write, branch, call, return), discards the queue and any in-flight fetch.

Parameters:
- ADDR_W, 13, program address width (matches PC width)
- INSTR_W, 14, instruction word width
- DEPTH, 2, prefetch queue entries (power of two, >=2)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- pc_in  input  ADDR_W  current PC value from program counter
- incr_pc_en  output  1  one-cycle pulse: advance PC
- imem_req  output  1  program memory read request
- imem_addr  output  ADDR_W  program memory address
- imem_ack  input  1  one-cycle pulse: imem_rdata valid, request complete
- imem_rdata  input  INSTR_W  instruction word returned with ack
- flush  input  1  discard queue and in-flight fetch; PC is being rewritten this cycle
- instr_valid  output  1  queue head valid
- instr_out  output  INSTR_W  queue head instruction
- instr_pc  output  ADDR_W  address the head was fetched from
- instr_ready  input  1  decoder consumes head when instr_valid && instr_ready

Behaviour:
- Reset (rst=0, asynchronous):
  - state=S_IDLE, count=0, read/write pointers=0, req_addr=0.
  - All outputs 0.
- States:
  - S_IDLE: one cycle after reset release, then unconditionally to S_FETCH. No request is issued.
  - S_FETCH: imem_req=(count<DEPTH); imem_addr=pc_in; req_addr<=pc_in every cycle while imem_req=1.
  - S_DRAIN: imem_req=1; imem_addr=req_addr (frozen). On imem_ack, the data is discarded, incr_pc_en stays 0, and the block goes to S_FETCH.
- Memory protocol:
  - Once raised, imem_req and imem_addr hold stable until imem_ack.
  - imem_ack is only honoured while imem_req=1.
  - Ack may arrive in the same cycle as req (zero wait states).
  - A new request may start the cycle after ack.
- Accept (S_FETCH, imem_ack=1, flush=0):
  - Push {imem_rdata, pc_in} into the queue.
  - incr_pc_en=1 in that same cycle (combinational), so the PC advances at that edge.
  - Exactly one incr pulse per accepted word.
- Pop: when instr_valid && instr_ready, advance the read pointer.
- Occupancy:
  - Push and pop in the same cycle: count unchanged.
  - count==DEPTH: imem_req=0, no push possible.
  - count==0: instr_valid=0; instr_out and instr_pc hold their last values (don't-care).
- instr_valid=(count!=0) && !flush. A pop cannot occur during a flush cycle.
- Flush (registered effect at the next edge):
  - count<=0 and pointers reset.
  - If imem_ack=1 that cycle: data discarded, incr_pc_en=0, stay in S_FETCH.
  - If imem_req=1 and imem_ack=0 in S_FETCH: go to S_DRAIN.
  - If imem_req=0: stay in S_FETCH.
  - Flush in S_DRAIN: remain in S_DRAIN; the request is unchanged.
  - Flush in S_IDLE: no effect.
- The first instruction after a flush is requested from the new pc_in once S_FETCH is re-entered.
- incr_pc_en is never asserted in S_IDLE or S_DRAIN, or in any flush cycle.
- Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- Reset mid-operation (including mid-S_DRAIN) aborts everything immediately. A late ack arriving after reset is ignored, because imem_req=0 in S_IDLE.

Test Plan:
- Reset and first fetch:
  - Stimulus: hold rst=0 for 3 cycles, release with pc_in=0x000.
  - Required: all outputs 0 during reset; one S_IDLE cycle; then imem_req=1, imem_addr=0x000.
- Streaming, zero-wait memory, instr_ready=1, ack every request:
  - Required: incr_pc_en pulses each ack cycle.
  - Decoder sees instr_out words with instr_pc=0x000,0x001,0x002 in order, with no gaps after the first word.
- Backpressure:
  - Stimulus: instr_ready=0, memory acks immediately.
  - Required: exactly 2 words queued, then imem_req=0 and no further incr pulses.
  - On instr_ready=1 for one cycle: one pop, then one new request at the next PC.
- Flush with outstanding request:
  - Stimulus: req to 0x010 pending with ack withheld; flush=1 while pc_in becomes 0x1A5.
  - Required: queue empties; imem_addr stays 0x010 until ack; ack data dropped with no incr pulse.
  - The next request is to 0x1A5.
- Flush and ack in the same cycle:
  - Required: word dropped; incr_pc_en=0; instr_valid=0 in that cycle.
  - Next cycle: request to the new pc_in; no S_DRAIN entry.
- Reset mid-drain:
  - Stimulus: assert rst=0 while in S_DRAIN, then release.
  - Required: imem_req drops to 0 asynchronously; a stray ack during reset is ignored.
  - Normal S_IDLE→S_FETCH sequence follows release.
